// File: rtl/axi_rd_burst_sched.sv
// axi_rd_burst_sched
// Splits one large read request (byte base address + word count) into AXI
// INCR bursts. Each burst is at most MAX_BURST beats and never crosses a
// 4 KB boundary. Bursts are issued one at a time over the engine's
// run/addr/length/ready/error interface. Completion is reported with a
// one-cycle done pulse and a sticky err flag.
//
// Optional build macro: AXI_RD_SCHED_ABORT_EN
//   defined   - a burst that completes with error=1 ends the request at once
//               (done=1, err=1); the remaining bursts are not issued.
//   undefined - errors only accumulate into err; every burst is issued.
module axi_rd_burst_sched #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int TOTAL_W   = 16,
    parameter int MAX_BURST = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [TOTAL_W-1:0]   total_words,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 run,
    output logic [ADDR_W-1:0]    addr,
    output logic [AXI_LEN_W-1:0] length,
    input  logic                 ready,
    input  logic                 error
);

    localparam int WORD_SHIFT = $clog2(DATA_W / 8);
    localparam int BEATS_W    = AXI_LEN_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << WORD_SHIFT) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_W-1:0]    cur_addr;
    logic [TOTAL_W-1:0]   remaining;
    logic [BEATS_W-1:0]   beats_q;
    logic [BEATS_W-1:0]   beats_calc;
    logic [12:0]          bnd_bytes;
    logic [12:0]          bnd_words;
    logic                 abort_now;

    // Words left before the next 4 KB boundary; at least 1 since cur_addr is word-aligned.
    assign bnd_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
    assign bnd_words = bnd_bytes >> WORD_SHIFT;

`ifdef AXI_RD_SCHED_ABORT_EN
    assign abort_now = error;
`else
    assign abort_now = 1'b0;
`endif

    // Burst size for the next burst: min(remaining, MAX_BURST, bnd_words).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        beats_calc = BEATS_W'(MAX_BURST);
        if (32'(remaining) <= 32'(MAX_BURST) && 32'(remaining) <= 32'(bnd_words)) begin
            beats_calc = remaining[BEATS_W-1:0];
        end else if (32'(bnd_words) <= 32'(MAX_BURST)) begin
            beats_calc = bnd_words[BEATS_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = CALC;
            CALC:    state_nxt = (remaining == '0) ? IDLE : ISSUE;
            ISSUE:   if (!ready) state_nxt = WAIT;
            WAIT:    if (ready)  state_nxt = abort_now ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; run follows the state register so it drops with the async reset.
    always_comb begin
        run = (state == ISSUE);
    end

    // Request bookkeeping and registered engine-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            beats_q   <= '0;
            addr      <= '0;
            length    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr & ALIGN_MASK;
                        remaining <= total_words;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                CALC: begin
                    if (remaining == '0) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        addr    <= cur_addr;
                        length  <= AXI_LEN_W'(beats_calc - BEATS_W'(1));
                        beats_q <= beats_calc;
                    end
                end
                WAIT: begin
                    if (ready) begin
                        err       <= err | error;
                        cur_addr  <= cur_addr + (ADDR_W'(beats_q) << WORD_SHIFT);
                        remaining <= remaining - TOTAL_W'(beats_q);
                        if (abort_now) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
